// File: rtl/viol_reset_seq.sv
// Violation reset sequencer: converts a level violation from the hardware
// monitors into a minimum-width PUC reset request, waits for the core's puc
// acknowledge (re-issuing on timeout) and keeps first-violation diagnostics.
module viol_reset_seq #(
  parameter logic [15:0] RST_HOLD    = 16'd8,
  parameter logic [15:0] PUC_TIMEOUT = 16'd64,
  parameter int          CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             viol,
  input  logic [15:0]      pc,
  input  logic [15:0]      data_addr,
  input  logic             puc,
  output logic             rst_req,
  output logic             busy,
  output logic [15:0]      viol_pc,
  output logic [15:0]      viol_addr,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             puc_timeout
);

  // Zero-length hold or timeout would make the down-counter wrap to 65535.
  if (RST_HOLD == 16'd0) begin : g_bad_hold
    $error("viol_reset_seq: RST_HOLD must be >= 1");
  end
  if (PUC_TIMEOUT == 16'd0) begin : g_bad_timeout
    $error("viol_reset_seq: PUC_TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_PUC = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Counters load N-1 and leave the state on the cycle they read zero,
  // giving exactly N cycles in the state.
  localparam logic [15:0]      HOLD_LD = RST_HOLD - 16'd1;
  localparam logic [15:0]      TO_LD   = PUC_TIMEOUT - 16'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [15:0] cnt;

  // Sequencer FSM with registered rst_req and diagnostic capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      rst_req     <= 1'b0;
      viol_pc     <= 16'd0;
      viol_addr   <= 16'd0;
      viol_cnt    <= '0;
      puc_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (viol) begin
            state     <= ASSERT;
            cnt       <= HOLD_LD;
            rst_req   <= 1'b1;
            viol_pc   <= pc;
            viol_addr <= data_addr;
            if (viol_cnt != CNT_MAX) viol_cnt <= viol_cnt + 1'b1;
          end
        end
        // viol and puc are both ignored here: the burst always completes.
        ASSERT: begin
          if (cnt == 16'd0) begin
            state   <= WAIT_PUC;
            cnt     <= TO_LD;
            rst_req <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        // puc takes priority over an expiring timeout on the same cycle.
        WAIT_PUC: begin
          if (puc) begin
            state <= RELEASE;
          end else if (cnt == 16'd0) begin
            state       <= ASSERT;
            cnt         <= HOLD_LD;
            rst_req     <= 1'b1;
            puc_timeout <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        // Requiring viol low before IDLE forces a deassert/reassert for a
        // new sequence.
        RELEASE: begin
          if (!puc && !viol) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          rst_req <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/viol_reset_seq.md
Name: viol_reset_seq

Overview:
- Sits directly downstream of the combined hardware-monitor violation output, i.e. the OR of the attestation-monitor and execution-monitor resets.
- Turns a single-cycle or multi-cycle violation into a clean, minimum-width reset request to the openMSP430 PUC logic.
- Waits for the core to acknowledge the request through puc, and re-issues it if no acknowledge arrives.
- Captures the PC and data address at the first violating cycle, plus a saturating violation count, for post-reset diagnostics.

Parameters:
- RST_HOLD, 16'd8: cycles rst_req is held high per assertion (legal range 1..65535).
- PUC_TIMEOUT, 16'd64: cycles allowed in WAIT_PUC for puc to rise before re-issue (legal range 1..65535).
- CNT_W, 8: width of the saturating violation counter.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- viol, input, 1: violation from the hardware-monitor top; level-sensitive, sampled every cycle.
- pc, input, 16: current CPU program counter.
- data_addr, input, 16: current data-bus address.
- puc, input, 1: core power-up-clear, used as the acknowledge.
- rst_req, output, 1: reset request to the core PUC logic.
- busy, output, 1: high in every state except IDLE.
- viol_pc, output, 16: pc captured at the first violation of a sequence.
- viol_addr, output, 16: data_addr captured at the same cycle.
- viol_cnt, output, CNT_W: saturating count of accepted violations.
- puc_timeout, output, 1: sticky flag, set when any PUC_TIMEOUT expires.

Behaviour:
- Reset (reset_n low, async): state=IDLE, rst_req=0, busy=0, viol_pc=0, viol_addr=0, viol_cnt=0, puc_timeout=0, internal counter=0. Nothing else clears these.
- States: IDLE, ASSERT, WAIT_PUC, RELEASE. Output rules:
  - rst_req is registered and high exactly in ASSERT.
  - busy = (state != IDLE).
- IDLE:
  - viol=1 at edge N: go to ASSERT; counter<=RST_HOLD-1; viol_pc<=pc; viol_addr<=data_addr; viol_cnt += 1, saturating at all-ones.
  - rst_req is first high in cycle N+1 (1-cycle latency).
- ASSERT:
  - Counter decrements each cycle.
  - When counter==0, go to WAIT_PUC with counter<=PUC_TIMEOUT-1.
  - rst_req is therefore high for exactly RST_HOLD cycles.
  - viol is ignored: no capture, no count.
- WAIT_PUC:
  - puc=1: go to RELEASE.
  - Otherwise, counter==0: set puc_timeout, go to ASSERT with counter<=RST_HOLD-1. Capture registers and count are unchanged.
  - Otherwise: counter decrements.
  - puc=1 and counter==0 in the same cycle: puc wins (RELEASE, no timeout flag).
- RELEASE:
  - Stay while puc=1 or viol=1.
  - Go to IDLE on the first cycle with puc=0 and viol=0.
  - A violation still asserted as PUC drops does not start a new sequence until it deasserts, then reasserts.
- puc may rise while in ASSERT (PUC from another source). This has no effect on the sequence; it completes normally.
- Captured fields are overwritten only on an IDLE->ASSERT transition. Each new sequence records its own first offending cycle.
- viol_cnt at all-ones stays at all-ones; there is no wrap.
- Counter widths are 16 bits and comparisons are unsigned.
- Parameter value 0 is illegal; synthesis/elaboration asserts RST_HOLD>=1 and PUC_TIMEOUT>=1.
- reset_n asserted mid-sequence returns to IDLE immediately. rst_req falls asynchronously.

Test Plan:
- Single pulse: viol high 1 cycle at edge 10, pc=16'hE1D0, data_addr=16'h6A04, puc pulse 3 cycles starting 2 cycles after rst_req falls.
  - Required: rst_req high cycles 11..18 (8 cycles).
  - Required: viol_pc=16'hE1D0, viol_addr=16'h6A04, viol_cnt=1, busy low again 1 cycle after puc falls, puc_timeout=0.
- No acknowledge: viol pulse, puc held 0.
  - Required: rst_req asserts 8 cycles, then 64 low cycles, then 8 cycles again, repeating.
  - Required: puc_timeout=1 after the first expiry; viol_cnt stays 1.
- Violation during sequence: viol held high for 20 cycles covering ASSERT and WAIT_PUC, puc acknowledged after rst_req.
  - Required: single 8-cycle rst_req burst, viol_cnt=1, capture unchanged.
  - Required: RELEASE held until viol falls.
- Saturation: CNT_W=8, 300 complete acknowledged sequences with distinct pc values.
  - Required: viol_cnt=255 and stays there.
  - Required: viol_pc equals the pc of the 300th sequence.
- Boundary coincidence: puc rises on the exact cycle the WAIT_PUC counter reaches 0.
  - Required: transition to RELEASE, puc_timeout stays 0, no re-issue.
- Async reset mid-ASSERT: reset_n low for 1 ns during the 4th rst_req cycle.
  - Required: rst_req=0, busy=0, viol_cnt=0 immediately, without waiting for a clock edge.
  - Required: a new viol after reset_n rises starts a fresh 8-cycle sequence.
